// File: rtl/bus_register_pkg.sv
// rtl/bus_register_pkg.sv - op codes and widths shared by bus_register and its users
package bus_register_pkg;
  localparam int OP_WIDTH = 3;

  localparam logic [OP_WIDTH-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_WIDTH-1:0] OP_LOAD = 3'd1;
  localparam logic [OP_WIDTH-1:0] OP_INC  = 3'd2;
  localparam logic [OP_WIDTH-1:0] OP_DEC  = 3'd3;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'd4;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'd5;
  localparam logic [OP_WIDTH-1:0] OP_CLR  = 3'd6;
endpackage

// File: rtl/tristate_bus_driver.sv
// rtl/tristate_bus_driver.sv - WIDTH-bit tri-state driver onto a shared bus
module tristate_bus_driver #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             outputEnable,
  output tri   [WIDTH-1:0] out
);
  assign out = outputEnable ? in : {WIDTH{1'bz}};
endmodule

// File: rtl/bus_register.sv
// rtl/bus_register.sv - WIDTH-bit register with load/inc/dec/shift/clear, carry flag and bus driver
module bus_register
  import bus_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]    data,
  input  logic                serial_in,
  input  logic                outputEnable,
  output tri   [WIDTH-1:0]    Q,
  output logic [WIDTH-1:0]    value,
  output logic                carry,
  output logic                zero
);
  logic [WIDTH-1:0] r_value;
  logic             r_carry;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  // The extra top bit of each sum is the wrap/borrow indication.
  assign w_inc = {1'b0, r_value} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, r_value} - {{WIDTH{1'b0}}, 1'b1};

  // Unknown op values fall through to default and hold state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= RESET_VALUE;
      r_carry <= 1'b0;
    end else begin
      case (op)
        OP_LOAD: r_value <= data;
        OP_INC:  {r_carry, r_value} <= w_inc;
        OP_DEC:  {r_carry, r_value} <= w_dec;
        OP_SHL: begin
          r_value <= {r_value[WIDTH-2:0], serial_in};
          r_carry <= r_value[WIDTH-1];
        end
        OP_SHR: begin
          r_value <= {serial_in, r_value[WIDTH-1:1]};
          r_carry <= r_value[0];
        end
        OP_CLR: begin
          r_value <= RESET_VALUE;
          r_carry <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign value = r_value;
  assign carry = r_carry;
  assign zero  = (r_value == '0);

  tristate_bus_driver #(.WIDTH(WIDTH)) u_bus_driver (
    .in           (r_value),
    .outputEnable (outputEnable),
    .out          (Q)
  );
endmodule

// File: tb/tb_bus_register.sv
// tb/tb_bus_register.sv - directed self-checking bench for bus_register
module tb_bus_register;
  import bus_register_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] data = 8'h00;
  logic       serial_in = 1'b0;
  logic       outputEnable = 1'b0;
  logic       tb_drive = 1'b0;
  logic [7:0] tb_bus_val = 8'h00;
  wire  [7:0] bus;
  logic [7:0] value;
  logic       carry;
  logic       zero;
  int         n_tests = 0;
  int         n_fail = 0;

  // A second driver on the bus shows whether the register has released it.
  assign bus = tb_drive ? tb_bus_val : 8'hzz;

  bus_register #(.WIDTH(8), .RESET_VALUE(8'h5A)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .data         (data),
    .serial_in    (serial_in),
    .outputEnable (outputEnable),
    .Q            (bus),
    .value        (value),
    .carry        (carry),
    .zero         (zero)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [2:0] o, input logic [7:0] d, input logic s, input logic r);
    op = o;
    data = d;
    serial_in = s;
    rst = r;
    @(posedge clk);
    #1;
    rst = 1'b0;
    op = OP_HOLD;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] v, input logic c, input logic z);
    check({tag, ".value"}, value, v);
    check({tag, ".carry"}, {7'd0, carry}, {7'd0, c});
    check({tag, ".zero"}, {7'd0, zero}, {7'd0, z});
  endtask

  initial begin
    step(OP_HOLD, 8'h00, 1'b0, 1'b1);
    check_state("reset", 8'h5A, 1'b0, 1'b0);
    step(OP_LOAD, 8'h00, 1'b0, 1'b0);
    check_state("load0", 8'h00, 1'b0, 1'b1);

    step(OP_LOAD, 8'hFE, 1'b0, 1'b0);
    step(OP_INC, 8'h00, 1'b0, 1'b0);
    check_state("inc_ff", 8'hFF, 1'b0, 1'b0);
    step(OP_INC, 8'h00, 1'b0, 1'b0);
    check_state("inc_wrap", 8'h00, 1'b1, 1'b1);
    step(OP_LOAD, 8'h00, 1'b0, 1'b0);
    check_state("load_keeps_carry", 8'h00, 1'b1, 1'b1);
    step(OP_INC, 8'h00, 1'b0, 1'b0);
    check_state("inc_01", 8'h01, 1'b0, 1'b0);

    step(OP_LOAD, 8'h00, 1'b0, 1'b0);
    step(OP_DEC, 8'h00, 1'b0, 1'b0);
    check_state("dec_borrow", 8'hFF, 1'b1, 1'b0);
    step(OP_DEC, 8'h00, 1'b0, 1'b0);
    check_state("dec_fe", 8'hFE, 1'b0, 1'b0);

    step(OP_LOAD, 8'b1000_0001, 1'b0, 1'b0);
    step(OP_SHL, 8'h00, 1'b0, 1'b0);
    check_state("shl", 8'b0000_0010, 1'b1, 1'b0);
    step(OP_SHR, 8'h00, 1'b1, 1'b0);
    check_state("shr", 8'b1000_0001, 1'b0, 1'b0);
    step(OP_SHL, 8'h00, 1'b1, 1'b0);
    check_state("shl_sin1", 8'b0000_0011, 1'b1, 1'b0);
    step(OP_SHR, 8'h00, 1'b0, 1'b0);
    check_state("shr_sin0", 8'b0000_0001, 1'b1, 1'b0);

    step(OP_LOAD, 8'h3C, 1'b0, 1'b0);
    outputEnable = 1'b0;
    tb_bus_val = 8'hC3;
    tb_drive = 1'b1;
    #1;
    check("bus_released", bus, 8'hC3);
    tb_drive = 1'b0;
    outputEnable = 1'b1;
    #1;
    check("bus_driven", bus, 8'h3C);
    step(OP_HOLD, 8'hAA, 1'b0, 1'b0);
    step(OP_HOLD, 8'hAA, 1'b0, 1'b0);
    step(OP_HOLD, 8'hAA, 1'b0, 1'b0);
    check_state("hold3", 8'h3C, 1'b1, 1'b0);
    check("bus_hold", bus, 8'h3C);

    step(OP_LOAD, 8'h77, 1'b0, 1'b0);
    check("load_while_driving", bus, 8'h77);
    outputEnable = 1'b0;
    step(OP_INC, 8'h00, 1'b0, 1'b0);
    check_state("oe_off_inc", 8'h78, 1'b0, 1'b0);

    step(OP_LOAD, 8'hFF, 1'b0, 1'b0);
    step(OP_INC, 8'h00, 1'b0, 1'b0);
    step(OP_LOAD, 8'h10, 1'b0, 1'b0);
    check_state("pre_rst", 8'h10, 1'b1, 1'b0);
    step(OP_INC, 8'h00, 1'b0, 1'b1);
    check_state("rst_priority", 8'h5A, 1'b0, 1'b0);

    step(OP_LOAD, 8'h00, 1'b0, 1'b0);
    step(OP_DEC, 8'h00, 1'b0, 1'b0);
    step(3'd7, 8'h12, 1'b1, 1'b0);
    check_state("op7_hold", 8'hFF, 1'b1, 1'b0);
    step(OP_CLR, 8'h12, 1'b0, 1'b0);
    check_state("clr", 8'h5A, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
